// File: rtl/legv8_bus_memory.sv
`default_nettype none
// ============================================================================
// Module      : legv8_bus_memory
// Description : Memory-mapped bus slave for a LEGv8 core. Holds a small
//               doubleword RAM plus three I/O registers (LEDS, CYCLES,
//               ERRCNT) behind a shared, tri-stated 64-bit data bus.
//               Reads have one cycle of latency. Writes are acknowledged
//               with a single-cycle ready pulse. Illegal accesses set a
//               sticky fault flag and bump a saturating error counter.
//
// Ports       : clock     - single clock, all state changes on rising edge
//               reset     - asynchronous, active-high
//               address   - byte address from the core
//               data      - shared bus; driven only during read responses
//               en_read   - core read request
//               en_write  - core write request
//               ready     - read data valid / write acknowledged
//               fault     - sticky access-error flag
//               leds      - LED register contents
//               err_count - saturating count of faulted accesses
//
// Revision    : 1.0 - initial release
// ============================================================================
module legv8_bus_memory #(
    parameter int          RAM_WORDS = 32,
    parameter logic [63:0] IO_BASE   = 64'h100
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [63:0] address,
    inout  wire  [63:0] data,
    input  logic        en_read,
    input  logic        en_write,
    output logic        ready,
    output logic        fault,
    output logic [15:0] leds,
    output logic [7:0]  err_count
);

    // ------------------------------------------------------------------------
    // Address map constants
    // ------------------------------------------------------------------------
    localparam int          c_idx_w       = $clog2(RAM_WORDS);
    localparam logic [63:0] c_ram_bytes   = 64'(RAM_WORDS) * 64'd8;
    localparam logic [63:0] c_leds_addr   = IO_BASE;
    localparam logic [63:0] c_cycles_addr = IO_BASE + 64'h8;
    localparam logic [63:0] c_errcnt_addr = IO_BASE + 64'h10;

    // ------------------------------------------------------------------------
    // State encoding. WR_HOLD is the "IDLE-blocked" condition: a write has
    // been acknowledged but the core still holds en_write, so nothing new
    // is accepted until it drops.
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_st_idle     = 2'd0;
    localparam logic [1:0] c_st_rd_valid = 2'd1;
    localparam logic [1:0] c_st_wr_ack   = 2'd2;
    localparam logic [1:0] c_st_wr_hold  = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;

    logic [63:0]        r_ram [RAM_WORDS];
    logic [63:0]        r_rdata;
    logic [63:0]        r_cycles;
    logic [15:0]        r_leds;
    logic [7:0]         r_err_count;
    logic               r_fault;

    logic [c_idx_w-1:0] w_ram_idx;
    logic               w_is_ram;
    logic               w_is_leds;
    logic               w_is_cycles;
    logic               w_is_errcnt;
    logic               w_mapped;
    logic               w_aligned;
    logic               w_read_only;
    logic               w_accept;
    logic               w_req_any;
    logic               w_fault_req;
    logic               w_do_read;
    logic               w_do_write;
    logic               w_drive;
    logic [63:0]        w_read_value;

    // ------------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------------
    assign w_ram_idx   = address[c_idx_w+2:3];
    assign w_is_ram    = (address < c_ram_bytes);
    assign w_is_leds   = (address == c_leds_addr);
    assign w_is_cycles = (address == c_cycles_addr);
    assign w_is_errcnt = (address == c_errcnt_addr);
    assign w_mapped    = w_is_ram | w_is_leds | w_is_cycles | w_is_errcnt;
    assign w_aligned   = (address[2:0] == 3'd0);
    assign w_read_only = w_is_cycles | w_is_errcnt;

    // Requests are only evaluated while idle; in every other state the
    // inputs are part of an access already in flight.
    assign w_accept    = (r_state == c_st_idle);
    assign w_req_any   = en_read | en_write;

    assign w_fault_req = w_accept & w_req_any &
                         (~w_aligned | ~w_mapped |
                          (en_write & w_read_only) |
                          (en_read & en_write));

    assign w_do_read   = w_accept & en_read  & ~en_write & ~w_fault_req;
    assign w_do_write  = w_accept & en_write & ~en_read  & ~w_fault_req;

    // ------------------------------------------------------------------------
    // Read source mux
    // ------------------------------------------------------------------------
    always_comb begin
        w_read_value = '0;
        if (w_is_ram) begin
            w_read_value = r_ram[w_ram_idx];
        end else if (w_is_leds) begin
            w_read_value = {48'd0, r_leds};
        end else if (w_is_cycles) begin
            w_read_value = r_cycles;
        end else if (w_is_errcnt) begin
            w_read_value = {56'd0, r_err_count};
        end
    end

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_do_read) begin
                    w_state_nxt = c_st_rd_valid;
                end else if (w_do_write) begin
                    w_state_nxt = c_st_wr_ack;
                end
            end
            c_st_rd_valid: begin
                if (!en_read) begin
                    w_state_nxt = c_st_idle;
                end
            end
            c_st_wr_ack: begin
                // A still-held en_write must not be seen as a new write.
                w_state_nxt = en_write ? c_st_wr_hold : c_st_idle;
            end
            c_st_wr_hold: begin
                if (!en_write) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // RAM
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RAM_WORDS; i++) begin
                r_ram[i] <= '0;
            end
        end else if (w_do_write && w_is_ram) begin
            r_ram[w_ram_idx] <= data;
        end
    end

    // ------------------------------------------------------------------------
    // Read data capture: the address is sampled once, on the accepting edge,
    // and held for the whole read response.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (w_do_read) begin
            r_rdata <= w_read_value;
        end
    end

    // ------------------------------------------------------------------------
    // I/O registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cycles <= '0;
        end else begin
            r_cycles <= r_cycles + 64'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_leds <= '0;
        end else if (w_do_write && w_is_leds) begin
            r_leds <= data[15:0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_fault     <= 1'b0;
            r_err_count <= '0;
        end else if (w_fault_req) begin
            r_fault <= 1'b1;
            if (r_err_count != 8'hFF) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs. Reset gates the bus and ready directly so they drop in the
    // same instant reset rises, not after the state register settles.
    // ------------------------------------------------------------------------
    assign w_drive   = ~reset & (r_state == c_st_rd_valid) & en_read & ~en_write;
    assign data      = w_drive ? r_rdata : {64{1'bz}};
    assign ready     = ~reset & (((r_state == c_st_rd_valid) & en_read) |
                                 (r_state == c_st_wr_ack));
    assign fault     = r_fault;
    assign leds      = r_leds;
    assign err_count = r_err_count;

endmodule
`default_nettype wire
